// File: rtl/tmr_hamming_voter_pipe_if.sv
// Handshake and data bundle between the triplicated datapath, the voter and
// the single-string consumer. The master modport is the producer/consumer
// side; the slave modport is the voter.
interface tmr_hamming_voter_pipe_if #(
  parameter int N_NIB = 1
);
  localparam int DATA_W = 4 * N_NIB;
  localparam int CW_W   = 7 * N_NIB;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic [DATA_W-1:0] data_3;
  logic [CW_W-1:0]   inj_mask;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              fault;
  logic [2:0]        mismatch_mask;
  logic [2:0]        replica_failed;
  logic [1:0]        status;
  logic              clr_failed;

  modport master (
    output in_valid, data_1, data_2, data_3, inj_mask, out_ready, clr_failed,
    input  in_ready, out_valid, out_data, fault, mismatch_mask, replica_failed, status
  );

  modport slave (
    input  in_valid, data_1, data_2, data_3, inj_mask, out_ready, clr_failed,
    output in_ready, out_valid, out_data, fault, mismatch_mask, replica_failed, status
  );
endinterface

// File: rtl/tmr_hamming_voter_pipe.sv
// Two-stage TMR voter with Hamming(7,4) single-error correction per nibble.
// S1 votes the encoded replicas, S2 decodes/corrects. Per-replica health
// counters mark a replica failed after FAULT_THRESH consecutive mismatching
// words; a small FSM summarises the failures as NORMAL/DEGRADED/UNSAFE.
module tmr_hamming_voter_pipe #(
  parameter int N_NIB        = 1,
  parameter int FAULT_THRESH = 4
) (
  input logic                      clk,
  input logic                      rst,
  tmr_hamming_voter_pipe_if.slave  bus
);
  localparam int DATA_W = 4 * N_NIB;
  localparam int CW_W   = 7 * N_NIB;
  localparam int CNT_W  = $clog2(FAULT_THRESH + 1);
  localparam logic [CNT_W-1:0] THR = CNT_W'(FAULT_THRESH);

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    DEGRADED = 2'b01,
    UNSAFE   = 2'b10
  } state_t;

  // Codeword bits {d3,d2,d1,p4,d0,p2,p1}: bit index = Hamming position - 1.
  function automatic logic [6:0] enc_nib(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
            d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [CW_W-1:0] enc_word(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < N_NIB; k++) c[7*k +: 7] = enc_nib(d[4*k +: 4]);
    return c;
  endfunction

  // Returns {corrected, data}; a nonzero syndrome names the position to flip.
  function automatic logic [4:0] dec_nib(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] f;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    f    = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    return {s != 3'd0, f[6], f[5], f[4], f[2]};
  endfunction

  logic [CW_W-1:0]   enc1, enc2, enc3, maj;
  logic [2:0]        mis;
  logic              adv;

  logic              v1;
  logic [CW_W-1:0]   vote_s1;
  logic [2:0]        mis_s1;

  logic [DATA_W-1:0] dec_data;
  logic              dec_fault;

  logic              out_valid_s2;
  logic [DATA_W-1:0] out_data_s2;
  logic              fault_s2;
  logic [2:0]        mm_s2;

  logic [CNT_W-1:0]  cnt [3];
  logic [2:0]        hit;
  logic [2:0]        failed;
  logic [1:0]        fail_count;

  state_t            state, state_nxt;

  assign enc1 = enc_word(bus.data_1);
  assign enc2 = enc_word(bus.data_2);
  assign enc3 = enc_word(bus.data_3);
  assign maj  = (enc1 & enc2) | (enc1 & enc3) | (enc2 & enc3);
  // Health compares against the vote before injection so the test hook never
  // ages a replica.
  assign mis  = {enc3 != maj, enc2 != maj, enc1 != maj};
  assign adv  = !out_valid_s2 || bus.out_ready;

  // S1: latch the injected vote, the per-replica mismatch flags and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      vote_s1 <= '0;
      mis_s1  <= '0;
    end else if (adv) begin
      v1      <= bus.in_valid;
      vote_s1 <= maj ^ bus.inj_mask;
      mis_s1  <= mis;
    end
  end

  // Decode and correct every nibble of the S1 vote.
  always_comb begin
    logic [4:0] nib;
    nib       = '0;
    dec_data  = '0;
    dec_fault = 1'b0;
    for (int unsigned k = 0; k < N_NIB; k++) begin
      nib                = dec_nib(vote_s1[7*k +: 7]);
      dec_data[4*k +: 4] = nib[3:0];
      dec_fault          = dec_fault | nib[4];
    end
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_s2 <= 1'b0;
      out_data_s2  <= '0;
      fault_s2     <= 1'b0;
      mm_s2        <= '0;
    end else if (adv) begin
      out_valid_s2 <= v1;
      out_data_s2  <= dec_data;
      fault_s2     <= dec_fault;
      mm_s2        <= mis_s1;
    end
  end

  // Threshold hits per replica.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < 3; i++) hit[i] = (cnt[i] == THR);
  end

  // Health counters and sticky failure flags; clear beats a same-cycle hit.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_failed) begin
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
      failed <= '0;
    end else begin
      failed <= failed | hit;
      if (adv && bus.in_valid) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (!mis[i])          cnt[i] <= '0;
          else if (cnt[i] != THR) cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fail_count = 2'(failed[0]) + 2'(failed[1]) + 2'(failed[2]);

  // Status state register.
  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  // Status next state: only moves forward unless cleared.
  always_comb begin
    state_nxt = state;
    if (bus.clr_failed) begin
      state_nxt = NORMAL;
    end else begin
      case (state)
        NORMAL: begin
          if (fail_count >= 2'd2)      state_nxt = UNSAFE;
          else if (fail_count == 2'd1) state_nxt = DEGRADED;
        end
        DEGRADED: if (fail_count >= 2'd2) state_nxt = UNSAFE;
        UNSAFE:   state_nxt = UNSAFE;
        default:  state_nxt = NORMAL;
      endcase
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.in_ready       = adv;
    bus.out_valid      = out_valid_s2;
    bus.out_data       = out_data_s2;
    bus.fault          = fault_s2;
    bus.mismatch_mask  = mm_s2;
    bus.replica_failed = failed;
    bus.status         = state;
  end
endmodule

// File: tb/tb_tmr_hamming_voter_pipe.sv
// Bench for tmr_hamming_voter_pipe: directed steps plus a random phase, with
// a reference model that votes by counting ones and decodes by nearest-codeword
// search.
module tb_tmr_hamming_voter_pipe;
  localparam int NN = 2;
  localparam int TH = 4;
  localparam int DW = 4 * NN;
  localparam int CW = 7 * NN;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic [2:0]    mm;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;
  exp_t q[$];

  tmr_hamming_voter_pipe_if #(.N_NIB(NN)) bus ();

  tmr_hamming_voter_pipe #(.N_NIB(NN), .FAULT_THRESH(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] henc(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // Nearest codeword within distance 1 (always exists for this perfect code).
  function automatic logic [4:0] hdec(input logic [6:0] c);
    for (int v = 0; v < 16; v++) begin
      logic [6:0] e;
      e = henc(4'(v));
      if ($countones(e ^ c) <= 1) return {e != c, 4'(v)};
    end
    return '0;
  endfunction

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] c, input logic [CW-1:0] inj);
    exp_t e;
    e = '0;
    for (int k = 0; k < NN; k++) begin
      logic [6:0] ea, eb, ec, m;
      logic [4:0] r;
      ea = henc(a[4*k +: 4]);
      eb = henc(b[4*k +: 4]);
      ec = henc(c[4*k +: 4]);
      for (int j = 0; j < 7; j++)
        m[j] = (int'(ea[j]) + int'(eb[j]) + int'(ec[j])) >= 2;
      if (ea != m) e.mm[0] = 1'b1;
      if (eb != m) e.mm[1] = 1'b1;
      if (ec != m) e.mm[2] = 1'b1;
      r = hdec(m ^ inj[7*k +: 7]);
      e.d[4*k +: 4] = r[3:0];
      if (r[4]) e.f = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: score output transfers and stalls, record accepted inputs.
  task automatic cycle();
    logic          stalled, r;
    logic [DW-1:0] hd;
    logic          hf;
    logic [2:0]    hm;
    exp_t          e;
    #1;
    r       = rst;
    stalled = bus.out_valid && !bus.out_ready;
    hd = bus.out_data; hf = bus.fault; hm = bus.mismatch_mask;
    if (!r && bus.out_valid && bus.out_ready) begin
      chk("out_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("fault", 32'(bus.fault), 32'(e.f));
        chk("mismatch_mask", 32'(bus.mismatch_mask), 32'(e.mm));
        delivered++;
      end
    end
    if (!r && bus.in_valid && bus.in_ready)
      q.push_back(model(bus.data_1, bus.data_2, bus.data_3, bus.inj_mask));
    @(posedge clk);
    #1;
    if (r) q.delete();
    if (stalled && !r) begin
      chk("hold_data", 32'(bus.out_data), 32'(hd));
      chk("hold_fault", 32'(bus.fault), 32'(hf));
      chk("hold_mm", 32'(bus.mismatch_mask), 32'(hm));
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [CW-1:0] inj);
    bus.in_valid = v;
    bus.data_1 = a; bus.data_2 = b; bus.data_3 = c;
    bus.inj_mask = inj;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, '0, '0);
    repeat (n) cycle();
  endtask

  task automatic drain();
    int budget;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    budget = 0;
    while (q.size() != 0 && budget < 50) begin
      cycle();
      budget++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] w [8];
    int            wi, c;
    logic          acc;
    logic [DW-1:0] base, d1, d2, d3;
    logic [CW-1:0] inj;

    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.clr_failed = 1'b0;
    drive(1'b0, '0, '0, '0, '0);

    // 1: reset for two cycles
    repeat (2) cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_mm", 32'(bus.mismatch_mask), 32'd0);
    chk("rst_failed", 32'(bus.replica_failed), 32'd0);
    chk("rst_status", 32'(bus.status), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 2: clean word, two-cycle latency
    drive(1'b1, 8'hAA, 8'hAA, 8'hAA, '0);
    cycle();
    drive(1'b0, '0, '0, '0, '0);
    chk("lat1_out_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("lat2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_data", 32'(bus.out_data), 32'hAA);
    chk("t2_fault", 32'(bus.fault), 32'd0);
    chk("t2_mm", 32'(bus.mismatch_mask), 32'd0);

    // 3: replica 2 outvoted
    drive(1'b1, 8'hCC, 8'hCC, 8'h88, '0);
    cycle();
    idle(1);
    chk("t3_data", 32'(bus.out_data), 32'hCC);
    chk("t3_fault", 32'(bus.fault), 32'd0);
    chk("t3_mm", 32'(bus.mismatch_mask), 32'b100);

    // 4: injected single-bit errors are corrected
    drive(1'b1, 8'hAA, 8'hAA, 8'hAA, {7'b0000100, 7'b0000100});
    cycle();
    drive(1'b1, 8'hAA, 8'hAA, 8'hAA, {7'b1000000, 7'b1000000});
    cycle();
    chk("t4a_data", 32'(bus.out_data), 32'hAA);
    chk("t4a_fault", 32'(bus.fault), 32'd1);
    idle(1);
    chk("t4b_data", 32'(bus.out_data), 32'hAA);
    chk("t4b_fault", 32'(bus.fault), 32'd1);
    idle(1);

    // 5a: threshold-1 mismatches, a match, threshold-1 again: no failure
    repeat (TH - 1) begin drive(1'b1, 8'h5A, 8'h5B, 8'h5A, '0); cycle(); end
    drive(1'b1, 8'h5A, 8'h5A, 8'h5A, '0); cycle();
    repeat (TH - 1) begin drive(1'b1, 8'h5A, 8'h5B, 8'h5A, '0); cycle(); end
    drive(1'b1, 8'h5A, 8'h5A, 8'h5A, '0); cycle();
    idle(3);
    chk("t5a_failed", 32'(bus.replica_failed), 32'd0);
    chk("t5a_status", 32'(bus.status), 32'd0);

    // 5b: replica 1 fails, then replica 0
    repeat (TH) begin drive(1'b1, 8'h3C, 8'hC3, 8'h3C, '0); cycle(); end
    idle(3);
    chk("t5b_failed", 32'(bus.replica_failed), 32'b010);
    chk("t5b_status", 32'(bus.status), 32'b01);
    repeat (TH) begin drive(1'b1, 8'h17, 8'h96, 8'h96, '0); cycle(); end
    idle(3);
    chk("t5c_failed", 32'(bus.replica_failed), 32'b011);
    chk("t5c_status", 32'(bus.status), 32'b10);
    bus.clr_failed = 1'b1;
    cycle();
    bus.clr_failed = 1'b0;
    chk("t5d_failed", 32'(bus.replica_failed), 32'd0);
    chk("t5d_status", 32'(bus.status), 32'd0);

    // 5e: clear in the same cycle as the threshold-reaching word wins
    repeat (TH - 1) begin drive(1'b1, 8'h42, 8'h42, 8'h24, '0); cycle(); end
    drive(1'b1, 8'h42, 8'h42, 8'h24, '0);
    bus.clr_failed = 1'b1;
    cycle();
    bus.clr_failed = 1'b0;
    repeat (TH - 1) begin drive(1'b1, 8'h42, 8'h42, 8'h24, '0); cycle(); end
    idle(3);
    chk("t5e_failed", 32'(bus.replica_failed), 32'd0);
    chk("t5e_status", 32'(bus.status), 32'd0);
    drain();

    // 6: 8-word stream with a 3-cycle consumer stall
    for (int i = 0; i < 8; i++) w[i] = 8'(8'h10 + 8'(i * 17));
    delivered = 0;
    wi = 0;
    c = 0;
    while (wi < 8 && c < 40) begin
      bus.out_ready = !(c >= 4 && c <= 6);
      drive(1'b1, w[wi], w[wi], w[wi], '0);
      #1;
      if (!bus.out_ready && bus.out_valid)
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      acc = bus.in_ready;
      cycle();
      if (acc) wi++;
      c++;
    end
    chk("stream_accepted", 32'(wi), 32'd8);
    drain();
    chk("stream_delivered", 32'(delivered), 32'd8);

    // 6b: reset while stalled discards in-flight words
    drive(1'b1, 8'h77, 8'h77, 8'h77, '0); cycle();
    drive(1'b1, 8'h66, 8'h66, 8'h66, '0); cycle();
    bus.out_ready = 1'b0;
    idle(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    idle(3);
    chk("midrst_no_out", 32'(bus.out_valid), 32'd0);

    // Random phase
    for (int n = 0; n < 400; n++) begin
      base = DW'($urandom);
      d1 = base; d2 = base; d3 = base;
      if ($urandom_range(5) == 0) d1 = d1 ^ DW'($urandom);
      if ($urandom_range(5) == 0) d2 = d2 ^ DW'($urandom);
      if ($urandom_range(5) == 0) d3 = d3 ^ DW'($urandom);
      case ($urandom_range(3))
        0, 1:    inj = '0;
        2:       inj = CW'(1) << $urandom_range(CW - 1);
        default: inj = CW'($urandom);
      endcase
      drive($urandom_range(3) != 0, d1, d2, d3, inj);
      bus.out_ready = $urandom_range(3) != 0;
      cycle();
    end
    drain();
    bus.clr_failed = 1'b1;
    cycle();
    bus.clr_failed = 1'b0;
    chk("final_failed", 32'(bus.replica_failed), 32'd0);
    chk("final_status", 32'(bus.status), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
